p4_router_page_allocator: RTL and testbench
===========================================

Name: p4_router_page_allocator

Overview:
- Free-page manager for the P4 router packet buffer; sits directly upstream of the queue-state store.
- Grants one buffer page per malloc request from the enqueue path. The enqueue path forwards the grant as malloc_approved / next_page_ptr in its tail-pointer write.
- Reclaims pages returned by the dequeue path once a page has been fully read.
- Enforces a per-queue page quota so one queue cannot exhaust the shared buffer.

Parameters:
- NUM_PAGES, 0, pages in shared buffer; must be >0 and a power of 2.
- NUM_EGR_PORTS, 0, egress ports; must be >0.
- NUM_QUEUES, NUM_EGR_PORTS*NUM_QUEUES_PER_EGR_PORT, total queues.
- MAX_PAGES_PER_QUEUE, NUM_PAGES, per-queue page quota; range 1..NUM_PAGES.

Ports:
- clk  in  1  sole clock
- sreset  in  1  synchronous, active-high reset
- malloc_req  in  1  request one page; single-cycle pulse per request
- malloc_queue  in  NUM_QUEUES_LOG  requesting queue
- malloc_rsp_valid  out  1  response strobe
- malloc_approved  out  1  grant (1) / deny (0); valid with malloc_rsp_valid
- malloc_page_ptr  out  NUM_PAGES_LOG  granted page; 0 when denied
- free_valid  in  1  page return; never backpressured
- free_queue  in  NUM_QUEUES_LOG  queue that owned the page
- free_page_ptr  in  NUM_PAGES_LOG  page being returned
- init_done  out  1  free list loaded; requests accepted
- free_page_count  out  NUM_PAGES_LOG+1  pages currently free
- err_overflow  out  1  sticky: free received with list full
- err_underflow  out  1  sticky: free for a queue holding 0 pages

Behaviour:
- Reset:
  - malloc_rsp_valid, malloc_approved, malloc_page_ptr, init_done, err_* = 0.
  - free_page_count = 0; all per-queue counters = 0; list rd/wr pointers = 0; FSM enters INIT.
  - Reset asserted in any state aborts the operation in progress and restarts INIT.
- FSM INIT:
  - Writes free_list[i] = i for i = 0..NUM_PAGES-1, one entry per cycle.
  - After the last write: free_page_count = NUM_PAGES, wr_ptr wraps to 0, init_done <= 1, go to RUN.
  - Duration is NUM_PAGES cycles after reset deassertion.
  - During INIT, malloc_req is answered with malloc_rsp_valid=1 and malloc_approved=0, still at 1-cycle latency; free_valid is ignored.
- FSM RUN:
  - Free list is a circular buffer in RAM with read/write pointers of NUM_PAGES_LOG bits; wrap is natural because NUM_PAGES is a power of 2.
  - Malloc latency is exactly 1 cycle: malloc_req at cycle N produces a response at N+1.
  - Grant condition: free_page_count>0 AND queue_pages[malloc_queue] < MAX_PAGES_PER_QUEUE.
  - On grant: malloc_page_ptr = free_list[rd_ptr] (registered read); rd_ptr++; count--; queue_pages[q]++.
  - On deny: no state change; malloc_page_ptr=0.
  - Free with count<NUM_PAGES and queue_pages[free_queue]>0: free_list[wr_ptr]=free_page_ptr; wr_ptr++; count++; queue_pages[free_queue]--.
  - Free with count==NUM_PAGES: dropped; err_overflow<=1.
  - Free with queue_pages[free_queue]==0: dropped; err_underflow<=1.
  - Simultaneous malloc and free are both processed in the same cycle:
    - The grant check uses the pre-cycle count; a free arriving with count==0 does not bypass, so the malloc is denied and the page is written.
    - Same queue on both sides: quota check uses the pre-cycle value; net counter change is 0.
    - free_page_count changes by net +1 / 0 / -1.
- Error flags clear only on reset.
- free_page_count is registered and reflects state after the last cycle's operations.
- Per-queue counters are NUM_PAGES_LOG+1 bits wide; saturation cannot occur when inputs are legal.
- No check for duplicate page identifiers on free; detecting those is a verification-side job.

Decomposition:
- p4_router_pkg:
  - NUM_QUEUES_PER_EGR_PORT (existing).
  - New typedef page_alloc_fsm_t {INIT, RUN}.
  - New struct malloc_rsp_t {approved, page_ptr}, reused by the enqueue block.
- One natural sub-module: p4_router_page_free_list. It holds the circular RAM, rd/wr pointers and count. Ports are push, push_data, pop, pop_data (registered) and count.
- The top level holds the FSM, quota counters and error logic.

Test Plan:
1. Init: NUM_PAGES=16, release reset. init_done rises exactly 16 cycles later with free_page_count=16. A malloc during INIT gets a response 1 cycle later with approved=0.
2. Sequential grants: 16 mallocs on queue 0, MAX=16. Pages returned are 0,1,…,15 in order, each response 1 cycle after its request. The 17th malloc is denied with page_ptr=0; count=0.
3. Quota: MAX=4, 5 mallocs on queue 2. First 4 approved, 5th denied while count=12. A malloc on queue 3 in the next cycle is approved.
4. Recycle/wrap: exhaust the list, free pages 7,3,9 on queue 0, then malloc 3 times. Granted order is 7,3,9; pointers wrap with no corruption.
5. Simultaneous: count=0, malloc and free(page 5) in the same cycle. Malloc is denied, count becomes 1, and the next malloc returns 5. With count=8 and malloc+free on the same queue, queue_pages is unchanged and count stays 8.
6. Errors/reset: a free on an empty-quota queue sets err_underflow. A free at full count sets err_overflow. Asserting sreset mid-RUN clears both flags and init_done, and re-INIT gives count=16 and pages issued from 0.

Source files
------------

// File: rtl/p4_router_pkg.sv
// Shared types and constants for the P4 router datapath blocks.
package p4_router_pkg;

    localparam int NUM_QUEUES_PER_EGR_PORT = 4;
    localparam int PAGE_PTR_MAX_W          = 16;

    typedef enum logic {
        INIT,
        RUN
    } page_alloc_fsm_t;

    // Malloc response handed to the enqueue path; page_ptr is sized for the largest buffer.
    typedef struct packed {
        logic                      approved;
        logic [PAGE_PTR_MAX_W-1:0] page_ptr;
    } malloc_rsp_t;

endpackage

// File: rtl/p4_router_page_free_list.sv
// Circular free-page list: RAM of page ids with read/write pointers and an occupancy count.
module p4_router_page_free_list #(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             sreset,
    input  logic             push,
    input  logic [PTR_W-1:0] push_data,
    input  logic             pop,
    output logic [PTR_W-1:0] pop_data,
    output logic [PTR_W:0]   count
);

    logic [PTR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // The caller never pops empty or pushes full, so rd/wr never address the same live entry.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
        if (pop) begin
            pop_data <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/p4_router_page_allocator.sv
// Free-page manager for the packet buffer: loads the free list after reset, grants pages
// against a per-queue quota and reclaims pages returned by the dequeue path.
module p4_router_page_allocator
    import p4_router_pkg::*;
#(
    parameter int NUM_PAGES           = 16,
    parameter int NUM_EGR_PORTS       = 2,
    parameter int NUM_QUEUES          = NUM_EGR_PORTS * NUM_QUEUES_PER_EGR_PORT,
    parameter int MAX_PAGES_PER_QUEUE = NUM_PAGES,
    localparam int NUM_PAGES_LOG      = $clog2(NUM_PAGES),
    localparam int NUM_QUEUES_LOG     = $clog2(NUM_QUEUES)
) (
    input  logic                      clk,
    input  logic                      sreset,
    input  logic                      malloc_req,
    input  logic [NUM_QUEUES_LOG-1:0] malloc_queue,
    output logic                      malloc_rsp_valid,
    output logic                      malloc_approved,
    output logic [NUM_PAGES_LOG-1:0]  malloc_page_ptr,
    input  logic                      free_valid,
    input  logic [NUM_QUEUES_LOG-1:0] free_queue,
    input  logic [NUM_PAGES_LOG-1:0]  free_page_ptr,
    output logic                      init_done,
    output logic [NUM_PAGES_LOG:0]    free_page_count,
    output logic                      err_overflow,
    output logic                      err_underflow
);

    localparam logic [NUM_PAGES_LOG:0]   FULL_COUNT = (NUM_PAGES_LOG+1)'(NUM_PAGES);
    localparam logic [NUM_PAGES_LOG:0]   QUOTA      = (NUM_PAGES_LOG+1)'(MAX_PAGES_PER_QUEUE);
    localparam logic [NUM_PAGES_LOG-1:0] LAST_PAGE  = NUM_PAGES_LOG'(NUM_PAGES-1);

    page_alloc_fsm_t            state_q, state_d;
    logic [NUM_PAGES_LOG-1:0]   init_idx_q;
    logic [NUM_PAGES_LOG:0]     queue_pages_q [NUM_QUEUES];
    logic [NUM_QUEUES-1:0]      q_inc, q_dec;
    logic                       list_push, list_pop;
    logic [NUM_PAGES_LOG-1:0]   list_push_data, list_pop_data;
    logic                       grant, free_accept, set_overflow, set_underflow;
    logic                       rsp_valid_q, approved_q, overflow_q, underflow_q;

    // All decisions use pre-cycle count and quota, so a same-cycle free never feeds a malloc.
    always_comb begin
        state_d        = state_q;
        list_push      = 1'b0;
        list_push_data = '0;
        list_pop       = 1'b0;
        grant          = 1'b0;
        free_accept    = 1'b0;
        set_overflow   = 1'b0;
        set_underflow  = 1'b0;
        case (state_q)
            INIT: begin
                list_push      = 1'b1;
                list_push_data = init_idx_q;
                if (init_idx_q == LAST_PAGE) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                grant          = malloc_req && (free_page_count != '0)
                                 && (queue_pages_q[malloc_queue] < QUOTA);
                set_overflow   = free_valid && (free_page_count == FULL_COUNT);
                set_underflow  = free_valid && (queue_pages_q[free_queue] == '0);
                free_accept    = free_valid && !set_overflow && !set_underflow;
                list_pop       = grant;
                list_push      = free_accept;
                list_push_data = free_page_ptr;
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            state_q     <= INIT;
            init_idx_q  <= '0;
            rsp_valid_q <= 1'b0;
            approved_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == INIT) begin
                init_idx_q <= init_idx_q + 1'b1;
            end
            rsp_valid_q <= malloc_req;
            approved_q  <= grant;
            overflow_q  <= overflow_q | set_overflow;
            underflow_q <= underflow_q | set_underflow;
        end
    end

    // A grant and an accepted free on the same queue cancel out.
    always_comb begin
        for (int q = 0; q < NUM_QUEUES; q++) begin
            q_inc[q] = grant && (malloc_queue == NUM_QUEUES_LOG'(q));
            q_dec[q] = free_accept && (free_queue == NUM_QUEUES_LOG'(q));
        end
    end

    always_ff @(posedge clk) begin
        for (int q = 0; q < NUM_QUEUES; q++) begin
            if (sreset) begin
                queue_pages_q[q] <= '0;
            end else if (q_inc[q] && !q_dec[q]) begin
                queue_pages_q[q] <= queue_pages_q[q] + 1'b1;
            end else if (q_dec[q] && !q_inc[q]) begin
                queue_pages_q[q] <= queue_pages_q[q] - 1'b1;
            end
        end
    end

    p4_router_page_free_list #(
        .DEPTH (NUM_PAGES),
        .PTR_W (NUM_PAGES_LOG)
    ) u_free_list (
        .clk       (clk),
        .sreset    (sreset),
        .push      (list_push),
        .push_data (list_push_data),
        .pop       (list_pop),
        .pop_data  (list_pop_data),
        .count     (free_page_count)
    );

    assign malloc_rsp_valid = rsp_valid_q;
    assign malloc_approved  = approved_q;
    assign malloc_page_ptr  = approved_q ? list_pop_data : '0;
    assign init_done        = (state_q == RUN);
    assign err_overflow     = overflow_q;
    assign err_underflow    = underflow_q;

endmodule

// File: tb/tb_p4_router_page_allocator.sv
// Bench for the page allocator: directed vectors on a full-quota instance, quota sequences and
// randomized traffic against a queue-based reference model on a quota-4 instance.
module tb_p4_router_page_allocator;

    localparam int NUM_PAGES  = 16;
    localparam int NUM_QUEUES = 8;
    localparam int QUOTA4     = 4;

    logic       clk;
    logic       sreset;
    logic       malloc_req;
    logic [2:0] malloc_queue;
    logic       free_valid;
    logic [2:0] free_queue;
    logic [3:0] free_page_ptr;

    logic       rsp_valid_16, approved_16, init_done_16, ovf_16, unf_16;
    logic [3:0] ptr_16;
    logic [4:0] count_16;
    logic       rsp_valid_4, approved_4, init_done_4, ovf_4, unf_4;
    logic [3:0] ptr_4;
    logic [4:0] count_4;

    int tests  = 0;
    int failed = 0;

    p4_router_page_allocator #(
        .NUM_PAGES(NUM_PAGES), .NUM_EGR_PORTS(2), .MAX_PAGES_PER_QUEUE(16)
    ) dut16 (
        .clk(clk), .sreset(sreset),
        .malloc_req(malloc_req), .malloc_queue(malloc_queue),
        .malloc_rsp_valid(rsp_valid_16), .malloc_approved(approved_16), .malloc_page_ptr(ptr_16),
        .free_valid(free_valid), .free_queue(free_queue), .free_page_ptr(free_page_ptr),
        .init_done(init_done_16), .free_page_count(count_16),
        .err_overflow(ovf_16), .err_underflow(unf_16)
    );

    p4_router_page_allocator #(
        .NUM_PAGES(NUM_PAGES), .NUM_EGR_PORTS(2), .MAX_PAGES_PER_QUEUE(QUOTA4)
    ) dut4 (
        .clk(clk), .sreset(sreset),
        .malloc_req(malloc_req), .malloc_queue(malloc_queue),
        .malloc_rsp_valid(rsp_valid_4), .malloc_approved(approved_4), .malloc_page_ptr(ptr_4),
        .free_valid(free_valid), .free_queue(free_queue), .free_page_ptr(free_page_ptr),
        .init_done(init_done_4), .free_page_count(count_4),
        .err_overflow(ovf_4), .err_underflow(unf_4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model for the quota-4 instance: free pages kept as a FIFO of ids.
    int  m_pool[$];
    int  m_qp[NUM_QUEUES];
    int  m_init_left = 0;
    bit  m_live = 0;
    bit  m_ovf, m_unf, e_valid, e_appr;
    int  e_ptr;

    always @(posedge clk) begin
        if (sreset) begin
            m_init_left = NUM_PAGES;
            m_pool.delete();
            foreach (m_qp[i]) m_qp[i] = 0;
            m_ovf = 0; m_unf = 0;
            e_valid = 0; e_appr = 0; e_ptr = 0;
            m_live = 1;
        end else if (m_init_left > 0) begin
            e_valid = malloc_req; e_appr = 0; e_ptr = 0;
            m_init_left--;
            if (m_init_left == 0)
                for (int p = 0; p < NUM_PAGES; p++) m_pool.push_back(p);
        end else begin
            int cnt;
            bit m_grant, m_take;
            cnt     = m_pool.size();
            m_grant = malloc_req && cnt > 0 && m_qp[malloc_queue] < QUOTA4;
            m_take  = free_valid && cnt < NUM_PAGES && m_qp[free_queue] > 0;
            if (free_valid && cnt == NUM_PAGES) m_ovf = 1;
            if (free_valid && m_qp[free_queue] == 0) m_unf = 1;
            e_valid = malloc_req; e_appr = m_grant; e_ptr = 0;
            if (m_grant) begin
                e_ptr = m_pool.pop_front();
                m_qp[malloc_queue]++;
            end
            if (m_take) begin
                m_pool.push_back(int'(free_page_ptr));
                m_qp[free_queue]--;
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic modelCheck();
        if (m_live) begin
            checkOutput("m4_rsp_valid", int'(rsp_valid_4), int'(e_valid));
            checkOutput("m4_approved", int'(approved_4), int'(e_appr));
            checkOutput("m4_page_ptr", int'(ptr_4), e_ptr);
            checkOutput("m4_init_done", int'(init_done_4), int'(m_init_left == 0));
            checkOutput("m4_err_ovf", int'(ovf_4), int'(m_ovf));
            checkOutput("m4_err_unf", int'(unf_4), int'(m_unf));
            if (m_init_left == 0) checkOutput("m4_count", int'(count_4), m_pool.size());
        end
    endtask

    // Drive one cycle of inputs, let the edge take them, then check the model a little after.
    task automatic applyStimulus(input int rst, input int req, input int mq,
                                 input int fv, input int fq, input int fp);
        sreset        = 1'(rst);
        malloc_req    = 1'(req);
        malloc_queue  = 3'(mq);
        free_valid    = 1'(fv);
        free_queue    = 3'(fq);
        free_page_ptr = 4'(fp);
        @(posedge clk);
        #1;
        modelCheck();
    endtask

    typedef struct {
        int req, mq, fv, fq, fp;
        int valid, appr, ptr, cnt, ovf, unf;
    } vec_t;

    function automatic vec_t mk(int req, int mq, int fv, int fq, int fp,
                                int valid, int appr, int ptr, int cnt, int ovf, int unf);
        vec_t v;
        v.req = req; v.mq = mq; v.fv = fv; v.fq = fq; v.fp = fp;
        v.valid = valid; v.appr = appr; v.ptr = ptr; v.cnt = cnt; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    task automatic waitInit(input string name);
        int cyc = 0;
        while (!init_done_16 && cyc < 40) begin
            applyStimulus(0, int'(cyc == 2), 0, 0, 0, 0);
            cyc++;
            if (cyc == 3) begin
                checkOutput({name, "_rsp_valid"}, int'(rsp_valid_16), 1);
                checkOutput({name, "_rsp_denied"}, int'(approved_16), 0);
                checkOutput({name, "_rsp_ptr"}, int'(ptr_16), 0);
            end
        end
        checkOutput({name, "_cycles"}, cyc, NUM_PAGES);
        checkOutput({name, "_count"}, int'(count_16), NUM_PAGES);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[$];

        for (int i = 0; i < 16; i++) vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, i, 15 - i, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 7, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 3, 0, 0, 0, 2, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 9, 0, 0, 0, 3, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 7, 2, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 3, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 9, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 5, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 1, 1, 5, 0, 0, 0));
        for (int p = 0; p < 8; p++) vecs.push_back(mk(0, 0, 1, 0, p, 0, 0, 0, p + 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 12, 1, 1, 0, 8, 0, 0));
        for (int p = 8; p < 15; p++) vecs.push_back(mk(0, 0, 1, 0, p, 0, 0, 0, p + 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 15, 0, 0, 0, 15, 0, 1));
        vecs.push_back(mk(0, 0, 1, 1, 5, 0, 0, 0, 16, 0, 1));
        vecs.push_back(mk(0, 0, 1, 1, 6, 0, 0, 0, 16, 1, 1));

        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("reset_init_done", int'(init_done_16), 0);
        checkOutput("reset_count", int'(count_16), 0);
        checkOutput("reset_rsp_valid", int'(rsp_valid_16), 0);
        checkOutput("reset_errs", int'({ovf_16, unf_16}), 0);
        waitInit("init");

        foreach (vecs[i]) begin
            applyStimulus(0, vecs[i].req, vecs[i].mq, vecs[i].fv, vecs[i].fq, vecs[i].fp);
            checkOutput($sformatf("vec%0d_valid", i), int'(rsp_valid_16), vecs[i].valid);
            checkOutput($sformatf("vec%0d_appr", i), int'(approved_16), vecs[i].appr);
            checkOutput($sformatf("vec%0d_ptr", i), int'(ptr_16), vecs[i].ptr);
            checkOutput($sformatf("vec%0d_count", i), int'(count_16), vecs[i].cnt);
            checkOutput($sformatf("vec%0d_ovf", i), int'(ovf_16), vecs[i].ovf);
            checkOutput($sformatf("vec%0d_unf", i), int'(unf_16), vecs[i].unf);
        end

        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("midrun_reset_ovf", int'(ovf_16), 0);
        checkOutput("midrun_reset_unf", int'(unf_16), 0);
        checkOutput("midrun_reset_init_done", int'(init_done_16), 0);
        waitInit("reinit");

        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 2, 0, 0, 0);
            checkOutput($sformatf("quota_q2_%0d_appr", i), int'(approved_4), int'(i < 4));
            checkOutput($sformatf("quota_q2_%0d_ptr", i), int'(ptr_4), (i < 4) ? i : 0);
            if (i == 0) checkOutput("reinit_first_ptr16", int'(ptr_16), 0);
        end
        checkOutput("quota_count_at_deny", int'(count_4), 12);
        applyStimulus(0, 1, 3, 0, 0, 0);
        checkOutput("quota_q3_appr", int'(approved_4), 1);
        checkOutput("quota_q3_ptr", int'(ptr_4), 4);

        for (int n = 0; n < 1500; n++) begin
            applyStimulus(int'($urandom_range(0, 199) == 0), int'($urandom_range(0, 1)),
                          int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                          int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
